// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
package sar_adc_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StConvert,
        StDone
    } sar_state_e;

    // Smallest usable settle and per-trial wait lengths
    localparam int unsigned SETTLE_MIN   = 1;
    localparam int unsigned CMP_WAIT_MIN = 3;

    // Conversions per channel when averaging is built in
    localparam int unsigned AVG_N = 4;

endpackage

// File: rtl/sar_adc_sync2.sv
// Two-flop synchroniser for the asynchronous comparator output.
module sar_adc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops, both cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sar_adc_seq.sv
// Successive-approximation ADC sequencer: scans enabled mux channels, drives the
// R-2R DAC code, resolves WIDTH-bit results into a one-entry valid/ready register.
// Optional build macro SAR_ADC_AVG_EN: convert each channel AVG_N times and
// report the truncated mean.
module sar_adc_seq
    import sar_adc_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NCH        = 4,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CMP_WAIT   = 3,
    localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [CHW-1:0]   ch_sel,
    output logic             sample,
    output logic             busy,
    output logic [WIDTH-1:0] res_data,
    output logic [CHW-1:0]   res_ch,
    output logic             res_valid,
    input  logic             res_ready
);

    // Out-of-range parameters are clamped to the smallest working values
    localparam int unsigned SETTLE_EFF = (SETTLE_CYC < SETTLE_MIN) ? SETTLE_MIN : SETTLE_CYC;
    localparam int unsigned CMPW_EFF   = (CMP_WAIT < CMP_WAIT_MIN) ? CMP_WAIT_MIN : CMP_WAIT;
    localparam int unsigned CNT_MAX    = (SETTLE_EFF > CMPW_EFF) ? SETTLE_EFF : CMPW_EFF;
    localparam int unsigned CNTW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BW         = $clog2(WIDTH);

    sar_state_e       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [CHW-1:0]   res_ch_q, res_ch_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] acc_new;
    logic [WIDTH-1:0] result;
    logic [CHW:0]     next_ch;
    logic             cmp_s;

`ifdef SAR_ADC_AVG_EN
    localparam int unsigned AW = $clog2(AVG_N);
    logic [AW-1:0]    avg_q, avg_d;
    logic [WIDTH+1:0] sum_q, sum_d;
`endif

    sar_adc_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    function automatic logic [CHW-1:0] lowest_en(input logic [NCH-1:0] m);
        logic [CHW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = CHW'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest enabled channel strictly above cur
    function automatic logic [CHW:0] next_en(input logic [NCH-1:0] m, input logic [CHW-1:0] cur);
        logic [CHW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, CHW'(i)};
        end
        return r;
    endfunction

    // Request is registered, so busy rises one cycle after start is sampled
    assign req_d = (start & (state_q == StIdle)) | cont;

    // Next-state, datapath and DAC drive
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        res_data_d  = res_data_q;
        res_ch_d    = res_ch_q;
        res_valid_d = res_valid_q;
        dac_code    = '0;
        trial       = acc_q | (WIDTH'(1) << bit_q);
        acc_new     = cmp_s ? trial : acc_q;
        next_ch     = next_en(mask_q, ch_q);
`ifdef SAR_ADC_AVG_EN
        avg_d       = avg_q;
        sum_d       = sum_q;
        result      = sum_q[WIDTH+1:2];
`else
        result      = acc_q;
`endif

        // Consumer drain; a load in DONE below overrides this
        if (res_valid_q && res_ready) res_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_q && (ch_mask != '0)) begin
                    state_d = StTrack;
                    mask_d  = ch_mask;
                    ch_d    = lowest_en(ch_mask);
                    cnt_d   = '0;
                end
            end
            StTrack: begin
                if (cnt_q == CNTW'(SETTLE_EFF - 1)) begin
                    state_d = StConvert;
                    cnt_d   = '0;
                    bit_d   = BW'(WIDTH - 1);
                    acc_d   = '0;
`ifdef SAR_ADC_AVG_EN
                    avg_d   = '0;
                    sum_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StConvert: begin
                dac_code = trial;
                if (cnt_q == CNTW'(CMPW_EFF - 1)) begin
                    cnt_d = '0;
                    acc_d = acc_new;
                    if (bit_q == '0) begin
`ifdef SAR_ADC_AVG_EN
                        sum_d = sum_q + (WIDTH + 2)'(acc_new);
                        if (avg_q == AW'(AVG_N - 1)) begin
                            state_d = StDone;
                        end else begin
                            // Next back-to-back conversion, no re-track
                            avg_d = avg_q + 1'b1;
                            acc_d = '0;
                            bit_d = BW'(WIDTH - 1);
                        end
`else
                        state_d = StDone;
`endif
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                dac_code = acc_q;
                if (!res_valid_q || res_ready) begin
                    res_data_d  = result;
                    res_ch_d    = ch_q;
                    res_valid_d = 1'b1;
                    cnt_d       = '0;
                    if (next_ch[CHW]) begin
                        state_d = StTrack;
                        ch_d    = next_ch[CHW-1:0];
                    end else if (cont && (ch_mask != '0)) begin
                        // Wrap starts a new scan, so pick up the current mask
                        state_d = StTrack;
                        mask_d  = ch_mask;
                        ch_d    = lowest_en(ch_mask);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            acc_q       <= '0;
            mask_q      <= '0;
            ch_q        <= '0;
            req_q       <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
            res_valid_q <= 1'b0;
`ifdef SAR_ADC_AVG_EN
            avg_q       <= '0;
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            req_q       <= req_d;
            res_data_q  <= res_data_d;
            res_ch_q    <= res_ch_d;
            res_valid_q <= res_valid_d;
`ifdef SAR_ADC_AVG_EN
            avg_q       <= avg_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign ch_sel    = ch_q;
    assign sample    = (state_q == StTrack);
    assign busy      = (state_q != StIdle);
    assign res_data  = res_data_q;
    assign res_ch    = res_ch_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Scoreboard bench for sar_adc_seq with a behavioural comparator model.
module tb_sar_adc_seq;

    localparam int W      = 8;
    localparam int N      = 4;
    localparam int SETTLE = 4;
    localparam int CW     = 3;
`ifdef SAR_ADC_AVG_EN
    localparam int NAVG   = 4;
`else
    localparam int NAVG   = 1;
`endif
    localparam int LAT     = SETTLE + NAVG * W * CW + 2;
    localparam int SPACING = SETTLE + NAVG * W * CW + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cont = 1'b0;
    logic [N-1:0] ch_mask = '0;
    logic         cmp_in;
    logic [W-1:0] dac_code;
    logic [1:0]   ch_sel;
    logic         sample;
    logic         busy;
    logic [W-1:0] res_data;
    logic [1:0]   res_ch;
    logic         res_valid;
    logic         res_ready = 1'b1;

    logic [W-1:0] vin [N];
    logic [15:0]  sb_q [$];
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    // Ideal comparator: Vin of the selected channel against the DAC
    assign cmp_in = (vin[ch_sel] >= dac_code);

    sar_adc_seq #(
        .WIDTH      (W),
        .NCH        (N),
        .SETTLE_CYC (SETTLE),
        .CMP_WAIT   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .cmp_in    (cmp_in),
        .dac_code  (dac_code),
        .ch_sel    (ch_sel),
        .sample    (sample),
        .busy      (busy),
        .res_data  (res_data),
        .res_ch    (res_ch),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges until res_valid is seen; an expired bound is a failure
    task automatic wait_valid(input int limit, output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!res_valid && k < limit);
        if (!res_valid) check("valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input int ch, input logic [W-1:0] d);
        sb_q.push_back({8'(ch), d});
    endtask

    // Pop and compare every result the consumer accepts
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", 32'(res_data), 32'(e[7:0]));
                check("sb_ch", 32'(res_ch), 32'(e[15:8]));
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < N; i++) vin[i] = '0;

        // Reset state
        tick(3);
        check("rst_dac", 32'(dac_code), 0);
        check("rst_ch_sel", 32'(ch_sel), 0);
        check("rst_sample", 32'(sample), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_res_ch", 32'(res_ch), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        rst = 1'b0;
        tick(2);

        // Single shot on channel 0
        ch_mask = 4'b0001;
        vin[0] = 8'hA5;
        push_exp(0, 8'hA5);
        pulse_start();
        check("busy_e0", 32'(busy), 0);
        tick(1);
        check("busy_e1", 32'(busy), 1);
        wait_valid(LAT + 20, k);
        check("lat_single", 32'(k + 1), 32'(LAT));
        check("busy_end", 32'(busy), 0);
        tick(3);

        // Extremes
        foreach (vin[i]) vin[i] = '0;
        push_exp(0, 8'h00);
        pulse_start();
        wait_valid(LAT + 20, k);
        tick(3);
        vin[0] = 8'hFF;
        push_exp(0, 8'hFF);
        pulse_start();
        wait_valid(LAT + 20, k);
        tick(3);

        // Continuous scan over channels 1 and 3, then drop cont
        ch_mask = 4'b1010;
        vin[1] = 8'h37;
        vin[3] = 8'hC8;
        push_exp(1, 8'h37);
        push_exp(3, 8'hC8);
        push_exp(1, 8'h37);
        push_exp(3, 8'hC8);
        cont = 1'b1;
        tick(1);
        wait_valid(LAT + 20, k);
        check("lat_cont", 32'(k), 32'(LAT));
        wait_valid(SPACING + 20, k);
        check("space_1", 32'(k), 32'(SPACING));
        cont = 1'b0;
        wait_valid(SPACING + 20, k);
        check("space_2", 32'(k), 32'(SPACING));
        wait_valid(SPACING + 20, k);
        check("space_3", 32'(k), 32'(SPACING));
        check("cont_idle", 32'(busy), 0);
        tick(SPACING + 10);
        check("cont_stopped", 32'(busy), 0);
        check("sb_drained_cont", 32'(sb_q.size()), 0);

        // Back-pressure: first result held, sequencer stalls in DONE
        res_ready = 1'b0;
        ch_mask = 4'b0011;
        vin[0] = 8'h5A;
        vin[1] = 8'h81;
        push_exp(0, 8'h5A);
        push_exp(1, 8'h81);
        pulse_start();
        wait_valid(LAT + 20, k);
        check("lat_stall", 32'(k), 32'(LAT));
        tick(SPACING + 10);
        begin
            logic [W-1:0] dac_s;
            dac_s = dac_code;
            check("hold_valid", 32'(res_valid), 1);
            check("hold_data", 32'(res_data), 32'h5A);
            check("hold_ch", 32'(res_ch), 0);
            check("stall_busy", 32'(busy), 1);
            tick(3);
            check("stall_dac", 32'(dac_code), 32'(dac_s));
            check("hold_data2", 32'(res_data), 32'h5A);
        end
        res_ready = 1'b1;
        tick(1);
        check("reload_valid", 32'(res_valid), 1);
        check("reload_data", 32'(res_data), 32'h81);
        check("reload_ch", 32'(res_ch), 1);
        check("reload_busy", 32'(busy), 0);
        tick(3);
        check("sb_drained_stall", 32'(sb_q.size()), 0);

        // Reset mid-CONVERT drops the in-flight conversion
        ch_mask = 4'b0001;
        pulse_start();
        tick(10);
        rst = 1'b1;
        tick(1);
        check("mid_dac", 32'(dac_code), 0);
        check("mid_ch_sel", 32'(ch_sel), 0);
        check("mid_sample", 32'(sample), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_res_data", 32'(res_data), 0);
        check("mid_res_ch", 32'(res_ch), 0);
        check("mid_res_valid", 32'(res_valid), 0);
        rst = 1'b0;
        tick(LAT + 10);
        check("mid_no_result", 32'(res_valid), 0);

        // Empty mask never starts a scan
        ch_mask = '0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("nomask_busy", 32'(busy), 0);
        end

        // Mid-scale on channel 0 (latency covers the averaging build too)
        ch_mask = 4'b0001;
        vin[0] = 8'h40;
        push_exp(0, 8'h40);
        pulse_start();
        wait_valid(LAT + 20, k);
        check("lat_mid", 32'(k), 32'(LAT));
        tick(3);
        check("sb_drained_end", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_adc_seq.md
# sar_adc_seq

Parametrised successive-approximation ADC sequencer for the analog tile. It drives an external R-2R DAC and analog channel mux, samples an asynchronous comparator, and resolves WIDTH-bit codes over NCH scanned channels. Results leave through a one-entry valid/ready output register. This block replaces the fixed analog pass-through top as the digital core of the ADC/DAC project.

## Interface
- WIDTH, 8: conversion resolution in bits; minimum 2.
- NCH, 4: number of mux channels; minimum 1. CHW = max(1, clog2(NCH)), derived.
- SETTLE_CYC, 4: track/settle cycles after a channel switch; minimum 1.
- CMP_WAIT, 3: cycles per bit trial; minimum 3, which covers DAC settle plus the synchroniser.
---
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request for one scan of enabled channels.
- cont  in  1  level; continuous scanning while high.
- ch_mask  in  NCH  channel enable mask, latched at scan start.
- cmp_in  in  1  asynchronous comparator output; 1 means Vin >= Vdac.
- dac_code  out  WIDTH  R-2R DAC code.
- ch_sel  out  CHW  analog mux select.
- sample  out  1  high during TRACK.
- busy  out  1  high whenever the sequencer is not in IDLE.
- res_data  out  WIDTH  conversion result.
- res_ch  out  CHW  channel tag of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.

## Operation
- States: IDLE, TRACK, CONVERT, DONE.
- **IDLE:**
  - Leave IDLE when (start | cont) and ch_mask != 0.
  - On leaving, latch the mask and set ch_sel to the lowest enabled channel.
  - If start or cont is high but ch_mask == 0, stay in IDLE.
- **TRACK:**
  - sample=1 and dac_code=0 for SETTLE_CYC cycles.
  - Then go to CONVERT.
- **CONVERT:**
  - Trials run MSB to LSB, one per bit i.
  - For each trial, dac_code = acc | (1<<i) for CMP_WAIT cycles.
  - On the last cycle of the trial, the synchronised comparator is sampled. If it is 1, bit i is kept; otherwise it is cleared.
  - After bit 0, go to DONE.
- **DONE:**
  - If the output register is empty, or res_ready is high this cycle, load res_data/res_ch and set res_valid.
  - Otherwise stall in DONE. dac_code, ch_sel and busy hold.
  - After loading, take the next enabled channel above ch_sel and go to TRACK.
  - If there is no such channel and cont=1, wrap to the lowest enabled channel. If cont=0, go to IDLE.
- **Output register:**
  - res_valid clears on res_valid & res_ready when no new load happens in the same cycle.
  - res_data and res_ch stay stable while res_valid & !res_ready.
- **Input rules:**
  - start is ignored while busy.
  - ch_mask changes mid-scan take effect at the next scan.
  - If cont drops mid-scan, the current scan finishes, then the block goes to IDLE.
- **Arithmetic:** acc is unsigned and WIDTH bits wide; no saturation is needed.

## Timing
- Reset values: dac_code=0, ch_sel=0, sample=0, busy=0, res_data=0, res_ch=0, res_valid=0. State is IDLE.
- Reset mid-operation discards the in-flight conversion and any pending result.
- res_valid rises SETTLE_CYC + WIDTH*CMP_WAIT + 2 cycles after the edge that samples start (with averaging: SETTLE_CYC + 4*WIDTH*CMP_WAIT + 2).
- busy rises one cycle after start is sampled.
- busy falls on the cycle DONE loads the final result of a single-shot scan.
- With res_ready held high, consecutive results are spaced SETTLE_CYC + WIDTH*CMP_WAIT + 1 cycles apart.
- cmp_in passes through 2 flops. The sample taken in a trial reflects the DAC code from at least CMP_WAIT-2 cycles earlier.

## Configuration
- SAR_ADC_AVG_EN defined:
  - Each channel is converted 4 times back-to-back, with TRACK only before the first conversion.
  - Results are summed in a WIDTH+2 accumulator; res_data = sum >> 2, truncated.
- Undefined: a single conversion per channel, and no accumulator exists.

## Structure
- Package sar_adc_pkg holds:
  - the state enum;
  - minimum-value constants (SETTLE_MIN=1, CMP_WAIT_MIN=3);
  - the averaging count constant AVG_N=4.
- Sub-module sar_adc_sync2 is the 2-flop synchroniser for cmp_in, reset to 0.

## Test plan
Settings: WIDTH=8, NCH=4, SETTLE_CYC=4, CMP_WAIT=3. Comparator model: cmp = (Vin[ch_sel] >= dac_code), 2-cycle latency allowed.

- Single-shot, mask=0001, Vin0=0xA5, start pulse -> one result 0xA5 on ch 0, res_valid at cycle 30, busy low afterwards.
- Extremes, Vin0=0x00 then 0xFF -> results 0x00 and 0xFF.
- mask=1010, cont=1, res_ready=1 -> results tagged ch1, ch3, ch1, ch3, spaced 29 cycles. Dropping cont during ch1 -> ch3 completes, then IDLE.
- res_ready=0, mask=0011 -> first result held stable; sequencer stalls in DONE with busy=1. Raising ready -> next result loads in the same cycle.
- rst pulse mid-CONVERT -> next cycle all outputs at reset values. start with mask=0 -> busy stays 0.
- SAR_ADC_AVG_EN build, Vin0=0x40 -> result 0x40 at cycle 102.
